game: RTL and testbench



---
 rtl/game.sv | 50 +++++
 tb/tb_game.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/game.sv
// rtl/game.sv - 8x8 Game of Life engine, one generation per clock.
// Define TORUS_WRAP_EN for a toroidal grid; otherwise cells outside the grid are dead.
module game (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] seed,
  output logic [63:0] gridOut
);

  logic [63:0] grid;
  logic [63:0] next_grid;

  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      logic [7:0] nb;
      logic [3:0] n;

      // k enumerates the 8 neighbours: 0..2 row above, 3/4 same row, 5..7 row below
      for (genvar k = 0; k < 8; k++) begin : g_nb
        localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
        localparam int DC = (k == 3) ? -1 : ((k == 4) ? 1 : ((k < 3) ? k - 1 : k - 6));
`ifdef TORUS_WRAP_EN
        localparam int NR = (r + DR + 8) % 8;
        localparam int NC = (c + DC + 8) % 8;
        assign nb[k] = grid[NR*8 + NC];
`else
        if ((r + DR >= 0) && (r + DR < 8) && (c + DC >= 0) && (c + DC < 8)) begin : g_in
          assign nb[k] = grid[(r + DR)*8 + (c + DC)];
        end else begin : g_out
          assign nb[k] = 1'b0;
        end
`endif
      end

      assign n = 4'($countones(nb));
      assign next_grid[r*8 + c] = (n == 4'd3) | (grid[r*8 + c] & (n == 4'd2));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grid <= seed;
    end else begin
      grid <= next_grid;
    end
  end

  assign gridOut = grid;

endmodule

// File: tb/tb_game.sv
// tb/tb_game.sv - scoreboard bench for the Game of Life engine.
module tb_game;

  logic        clk;
  logic        reset;
  logic [63:0] seed;
  logic [63:0] gridOut;

  int tests_run = 0;
  int tests_failed = 0;
  bit stim_done = 0;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];

  game dut (
    .clk(clk),
    .reset(reset),
    .seed(seed),
    .gridOut(gridOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] LONE    = 64'h0000_0000_0800_0000;
  localparam logic [63:0] CORNER  = 64'h0000_0000_0000_0103;
  localparam logic [63:0] CORNER2 = 64'h0000_0000_0000_0303;
  localparam logic [63:0] WRAP    = 64'h0100_0000_0000_0101;
`ifdef TORUS_WRAP_EN
  localparam logic [63:0] WRAP1   = 64'h0000_0000_0000_0083;
  localparam logic [63:0] WRAP2   = WRAP;
`else
  localparam logic [63:0] WRAP1   = 64'h0;
  localparam logic [63:0] WRAP2   = 64'h0;
`endif

  // Drive one cycle's inputs and queue the gridOut expected after the next edge.
  task automatic step(input logic rst, input logic [63:0] sd, input logic [63:0] ev,
                      input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst;
    seed  = sd;
    e.name = nm;
    e.val  = ev;
    exp_q.push_back(e);
  endtask

  // Monitor: one output sample per cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests_run++;
      if (gridOut !== e.val) begin
        tests_failed++;
        $display("FAIL %s: gridOut=%016h expected=%016h", e.name, gridOut, e.val);
      end
    end
  end

  initial begin
    reset = 1'b1;
    seed  = 64'h0;

    // Blinker, with reset held two cycles while seed changes
    step(1'b1, LONE,    LONE,    "reset_track_a");
    step(1'b1, BLINK_H, BLINK_H, "reset_blinker");
    for (int i = 0; i < 6; i++)
      step(1'b0, BLINK_H, (i % 2 == 0) ? BLINK_V : BLINK_H, "blinker_run");

    // Still life
    step(1'b1, BLOCK, BLOCK, "reset_block");
    for (int i = 0; i < 10; i++)
      step(1'b0, BLOCK, BLOCK, "block_hold");

    // Empty grid
    step(1'b1, 64'h0, 64'h0, "reset_empty");
    for (int i = 0; i < 3; i++)
      step(1'b0, 64'h0, 64'h0, "empty_hold");

    // Lone cell dies
    step(1'b1, LONE, LONE, "reset_lone");
    step(1'b0, LONE, 64'h0, "lone_dies");
    step(1'b0, LONE, 64'h0, "lone_stays_dead");

    // Corner birth
    step(1'b1, CORNER, CORNER, "reset_corner");
    for (int i = 0; i < 3; i++)
      step(1'b0, CORNER, CORNER2, "corner_block");

    // Boundary handling
    step(1'b1, WRAP, WRAP, "reset_wrap");
    step(1'b0, WRAP, WRAP1, "wrap_gen1");
    step(1'b0, WRAP, WRAP2, "wrap_gen2");

    // Reset mid-run
    step(1'b1, BLINK_H, BLINK_H, "reset_mid_blinker");
    step(1'b0, BLINK_H, BLINK_V, "mid_run1");
    step(1'b0, BLINK_H, BLINK_H, "mid_run2");
    step(1'b0, BLINK_H, BLINK_V, "mid_run3");
    step(1'b1, BLOCK,   BLOCK,   "mid_reset_block");
    for (int i = 0; i < 4; i++)
      step(1'b0, BLOCK, BLOCK, "mid_block_hold");

    stim_done = 1;
  end

  initial begin
    int guard;
    wait (stim_done);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expected outputs never checked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule
